// File: rtl/data_store.sv
// data_store: drains 64-bit data words from the splitter FIFO and writes them
// round-robin into BANK_NUM SRAM banks, starting at a base address with a fixed
// depth per bank. It reports completion and length mismatches.
// Optional build macro: DS_PARITY_EN adds a per-byte even-parity output
// (sram_wpar) that is registered alongside sram_wdata.
module data_store #(
  parameter int TBITS    = 64,
  parameter int ADDR_W   = 12,
  parameter int BANK_NUM = 4,
  parameter int BANK_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ds_empty_n,
  output logic                ds_read,
  input  logic [TBITS-1:0]    fifo_data_din,
  input  logic                fifo_last_din,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [ADDR_W-1:0]   cfg_bank_depth,
  input  logic [15:0]         cfg_word_num,
  output logic [BANK_NUM-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [TBITS-1:0]    sram_wdata,
  output logic                ld_busy,
  output logic                ld_done,
  output logic                ld_err,
  output logic [15:0]         ld_word_cnt
`ifdef DS_PARITY_EN
  ,
  output logic [TBITS/8-1:0]  sram_wpar
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t              r_state;
  logic [BANK_W-1:0]   r_bank;
  logic [ADDR_W-1:0]   r_offset;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_depth_m1;   // latched depth minus one; a depth of 0 acts as 1
  logic [15:0]         r_word_num;

  logic                w_xfer;
  logic [15:0]         w_cnt_nxt;
  logic                w_cnt_hit;
  logic [BANK_NUM-1:0] w_wen;

  // A word moves only while loading and the FIFO has one
  assign ds_read   = (r_state == S_LOAD) && ds_empty_n;
  assign w_xfer    = ds_read;
  assign w_cnt_nxt = (ld_word_cnt == 16'hFFFF) ? 16'hFFFF : ld_word_cnt + 16'd1;
  assign w_cnt_hit = (w_cnt_nxt == r_word_num);
  assign w_wen     = {{(BANK_NUM-1){1'b0}}, 1'b1} << r_bank;

`ifdef DS_PARITY_EN
  logic [TBITS/8-1:0] w_par;
  for (genvar gi = 0; gi < TBITS/8; gi++) begin : g_par
    assign w_par[gi] = ^fifo_data_din[8*gi +: 8];
  end

  // Parity is registered with the write and reads 0 on idle cycles
  always_ff @(posedge clk) begin
    if (reset)       sram_wpar <= '0;
    else if (w_xfer) sram_wpar <= w_par;
    else             sram_wpar <= '0;
  end
`endif

  // Load sequencer: config latch, bank/offset walk, registered SRAM write, status
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bank      <= '0;
      r_offset    <= '0;
      r_base      <= '0;
      r_depth_m1  <= '0;
      r_word_num  <= '0;
      sram_wen    <= '0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      ld_busy     <= 1'b0;
      ld_done     <= 1'b0;
      ld_err      <= 1'b0;
      ld_word_cnt <= '0;
    end else begin
      sram_wen <= '0;
      ld_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ds_empty_n) begin
            r_state     <= S_LOAD;
            ld_busy     <= 1'b1;
            ld_word_cnt <= '0;
            ld_err      <= 1'b0;
            r_bank      <= '0;
            r_offset    <= '0;
            r_base      <= cfg_base_addr;
            r_depth_m1  <= (cfg_bank_depth == '0) ? '0 : cfg_bank_depth - 1'b1;
            r_word_num  <= cfg_word_num;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            sram_wen    <= w_wen;
            sram_addr   <= r_base + r_offset;
            sram_wdata  <= fifo_data_din;
            ld_word_cnt <= w_cnt_nxt;
            if (r_offset == r_depth_m1) begin
              r_offset <= '0;
              r_bank   <= r_bank + 1'b1;
            end else begin
              r_offset <= r_offset + 1'b1;
            end
            // Short burst flags on the last word, long burst as soon as the count is reached
            if (r_word_num != 16'd0) begin
              if (fifo_last_din && !w_cnt_hit) ld_err <= 1'b1;
              if (!fifo_last_din && w_cnt_hit) ld_err <= 1'b1;
            end
            if (fifo_last_din) begin
              r_state <= S_DONE;
              ld_done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          ld_busy <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_store.sv
// Directed bench for data_store: reset, basic load, stalls, bank wrap,
// length errors, mid-load reset, address wrap (and parity with DS_PARITY_EN).
module tb_data_store;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_empty_n;
  logic        ds_read;
  logic [63:0] fifo_data_din;
  logic        fifo_last_din;
  logic [11:0] cfg_base_addr;
  logic [11:0] cfg_bank_depth;
  logic [15:0] cfg_word_num;
  logic [3:0]  sram_wen;
  logic [11:0] sram_addr;
  logic [63:0] sram_wdata;
  logic        ld_busy, ld_done, ld_err;
  logic [15:0] ld_word_cnt;
`ifdef DS_PARITY_EN
  logic [7:0]  sram_wpar;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_store dut (
    .clk(clk), .reset(reset), .ds_empty_n(ds_empty_n), .ds_read(ds_read),
    .fifo_data_din(fifo_data_din), .fifo_last_din(fifo_last_din),
    .cfg_base_addr(cfg_base_addr), .cfg_bank_depth(cfg_bank_depth),
    .cfg_word_num(cfg_word_num), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .ld_busy(ld_busy), .ld_done(ld_done),
    .ld_err(ld_err), .ld_word_cnt(ld_word_cnt)
`ifdef DS_PARITY_EN
    , .sram_wpar(sram_wpar)
`endif
  );

  // Write/done log, sampled just after each rising edge
  logic [3:0]  wl_wen  [64];
  logic [11:0] wl_addr [64];
  logic [63:0] wl_data [64];
  int wn = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (sram_wen != 4'b0 && wn < 64) begin
      wl_wen[wn]  = sram_wen;
      wl_addr[wn] = sram_addr;
      wl_data[wn] = sram_wdata;
      wn++;
    end
    if (ld_done) done_cnt++;
  end

  task automatic clear_log();
    wn = 0;
    done_cnt = 0;
  endtask

  // Present a word and hold it until the DUT consumes it; returns at the next negedge
  task automatic send(input logic [63:0] d, input logic last);
    int n = 0;
    ds_empty_n = 1'b1; fifo_data_din = d; fifo_last_din = last;
    #1;
    while (!ds_read && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (ds_read !== 1'b1) begin
      errors++; $display("FAIL send_timeout ds_read=%0b want 1", ds_read);
    end
    @(negedge clk);
    fifo_last_din = 1'b0;
  endtask

  task automatic finish_load();
    ds_empty_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; ds_empty_n = 1'b0; fifo_data_din = '0; fifo_last_din = 1'b0;
    cfg_base_addr = '0; cfg_bank_depth = '0; cfg_word_num = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ds_read, sram_wen, sram_addr, sram_wdata, ld_busy, ld_done, ld_err, ld_word_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rd=%0b wen=%h addr=%h wd=%h busy=%0b done=%0b err=%0b cnt=%0d want all 0",
               ds_read, sram_wen, sram_addr, sram_wdata, ld_busy, ld_done, ld_err, ld_word_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_log();
    cfg_base_addr = 12'h010; cfg_bank_depth = 12'd4; cfg_word_num = 16'd6;
    send(64'hA0, 1'b0);
    checks++;
    if (sram_wen !== 4'b0001 || sram_addr !== 12'h010 || sram_wdata !== 64'hA0 || ld_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_first_write wen=%h addr=%h wd=%h busy=%0b want 1 010 a0 1",
               sram_wen, sram_addr, sram_wdata, ld_busy);
    end
    for (int i = 1; i < 6; i++) send(64'hA0 + 64'(i), i == 5);
    finish_load();
    checks++;
    if (wn !== 6 || done_cnt !== 1 || ld_word_cnt !== 16'd6 || ld_err !== 1'b0 || ld_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_status writes=%0d done=%0d cnt=%0d err=%0b busy=%0b want 6 1 6 0 0",
               wn, done_cnt, ld_word_cnt, ld_err, ld_busy);
    end
    for (int i = 0; i < 6 && i < wn; i++) begin
      logic [3:0]  ew = 4'b0001 << (i / 4);
      logic [11:0] ea = 12'h010 + 12'(i % 4);
      checks++;
      if (wl_wen[i] !== ew || wl_addr[i] !== ea || wl_data[i] !== 64'hA0 + 64'(i)) begin
        errors++;
        $display("FAIL basic_write%0d wen=%h addr=%h wd=%h want %h %h %h",
                 i, wl_wen[i], wl_addr[i], wl_data[i], ew, ea, 64'hA0 + 64'(i));
      end
    end
  endtask

  task automatic test_stalls();
    clear_log();
    cfg_base_addr = 12'h100; cfg_bank_depth = 12'd3; cfg_word_num = 16'd8;
    for (int i = 0; i < 8; i++) begin
      send(64'h5500 + 64'(i), i == 7);
      if (i % 2 == 0 && i < 7) begin
        ds_empty_n = 1'b0;
        #1;
        checks++;
        if (ds_read !== 1'b0 || ld_word_cnt !== 16'(i + 1)) begin
          errors++;
          $display("FAIL stall_hold%0d rd=%0b cnt=%0d want 0 %0d", i, ds_read, ld_word_cnt, i + 1);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ld_word_cnt !== 16'(i + 1) || sram_wen !== 4'b0) begin
          errors++;
          $display("FAIL stall_after%0d cnt=%0d wen=%h want %0d 0", i, ld_word_cnt, sram_wen, i + 1);
        end
      end
    end
    finish_load();
    checks++;
    if (wn !== 8 || done_cnt !== 1) begin
      errors++; $display("FAIL stall_count writes=%0d done=%0d want 8 1", wn, done_cnt);
    end
    for (int i = 0; i < 8 && i < wn; i++) begin
      logic [3:0]  ew = 4'b0001 << (i / 3);
      logic [11:0] ea = 12'h100 + 12'(i % 3);
      checks++;
      if (wl_wen[i] !== ew || wl_addr[i] !== ea || wl_data[i] !== 64'h5500 + 64'(i)) begin
        errors++;
        $display("FAIL stall_write%0d wen=%h addr=%h wd=%h want %h %h %h",
                 i, wl_wen[i], wl_addr[i], wl_data[i], ew, ea, 64'h5500 + 64'(i));
      end
    end
  endtask

  task automatic test_bank_wrap();
    logic [3:0] exp_w [5];
    exp_w[0] = 4'b0001; exp_w[1] = 4'b0010; exp_w[2] = 4'b0100; exp_w[3] = 4'b1000; exp_w[4] = 4'b0001;
    clear_log();
    cfg_base_addr = 12'h020; cfg_bank_depth = 12'd1; cfg_word_num = 16'd0;
    send(64'h1, 1'b0);
    // Config changes mid-load must be ignored
    cfg_base_addr = 12'h000; cfg_bank_depth = 12'd4;
    for (int i = 1; i < 5; i++) send(64'(i + 1), i == 4);
    finish_load();
    checks++;
    if (wn !== 5) begin errors++; $display("FAIL wrap_count writes=%0d want 5", wn); end
    for (int i = 0; i < 5 && i < wn; i++) begin
      checks++;
      if (wl_wen[i] !== exp_w[i] || wl_addr[i] !== 12'h020) begin
        errors++;
        $display("FAIL wrap_write%0d wen=%h addr=%h want %h 020", i, wl_wen[i], wl_addr[i], exp_w[i]);
      end
    end
    // Depth 0 behaves as depth 1
    clear_log();
    cfg_base_addr = 12'h030; cfg_bank_depth = 12'd0;
    send(64'h7, 1'b0);
    send(64'h8, 1'b1);
    finish_load();
    checks++;
    if (wn !== 2 || wl_wen[0] !== 4'b0001 || wl_wen[1] !== 4'b0010 || wl_addr[1] !== 12'h030) begin
      errors++;
      $display("FAIL depth0 writes=%0d wen0=%h wen1=%h addr1=%h want 2 1 2 030",
               wn, wl_wen[0], wl_wen[1], wl_addr[1]);
    end
  endtask

  task automatic test_len_err();
    // Short burst: 3 words against an expected 4
    clear_log();
    cfg_base_addr = 12'h000; cfg_bank_depth = 12'd8; cfg_word_num = 16'd4;
    send(64'h1, 1'b0);
    send(64'h2, 1'b0);
    checks++;
    if (ld_err !== 1'b0) begin errors++; $display("FAIL short_early err=%0b want 0", ld_err); end
    send(64'h3, 1'b1);
    finish_load();
    checks++;
    if (ld_err !== 1'b1 || ld_word_cnt !== 16'd3 || done_cnt !== 1) begin
      errors++; $display("FAIL short_err err=%0b cnt=%0d done=%0d want 1 3 1", ld_err, ld_word_cnt, done_cnt);
    end
    // Long burst: 4 words against an expected 2
    clear_log();
    cfg_word_num = 16'd2;
    send(64'h1, 1'b0);
    checks++;
    if (ld_err !== 1'b0) begin errors++; $display("FAIL long_cleared err=%0b want 0", ld_err); end
    send(64'h2, 1'b0);
    checks++;
    if (ld_err !== 1'b1 || ld_busy !== 1'b1) begin
      errors++; $display("FAIL long_at2 err=%0b busy=%0b want 1 1", ld_err, ld_busy);
    end
    send(64'h3, 1'b0);
    send(64'h4, 1'b1);
    finish_load();
    checks++;
    if (ld_err !== 1'b1 || ld_word_cnt !== 16'd4 || wn !== 4 || done_cnt !== 1) begin
      errors++;
      $display("FAIL long_end err=%0b cnt=%0d writes=%0d done=%0d want 1 4 4 1", ld_err, ld_word_cnt, wn, done_cnt);
    end
    // Clean load clears the flag
    clear_log();
    cfg_word_num = 16'd3;
    send(64'h1, 1'b0);
    send(64'h2, 1'b0);
    send(64'h3, 1'b1);
    finish_load();
    checks++;
    if (ld_err !== 1'b0 || ld_word_cnt !== 16'd3) begin
      errors++; $display("FAIL clean_load err=%0b cnt=%0d want 0 3", ld_err, ld_word_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    cfg_base_addr = 12'h040; cfg_bank_depth = 12'd4; cfg_word_num = 16'd6;
    for (int i = 0; i < 3; i++) send(64'hC0 + 64'(i), 1'b0);
    reset = 1'b1; ds_empty_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sram_wen !== 4'b0 || ld_busy !== 1'b0 || ld_word_cnt !== 16'd0 || ds_read !== 1'b0 || sram_addr !== 12'h0) begin
      errors++;
      $display("FAIL midreset_out wen=%h busy=%0b cnt=%0d rd=%0b addr=%h want 0 0 0 0 0",
               sram_wen, ld_busy, ld_word_cnt, ds_read, sram_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || wn !== 3) begin
      errors++; $display("FAIL midreset_nodone done=%0d writes=%0d want 0 3", done_cnt, wn);
    end
    clear_log();
    send(64'hD0, 1'b0);
    send(64'hD1, 1'b1);
    finish_load();
    checks++;
    if (wn !== 2 || wl_wen[0] !== 4'b0001 || wl_addr[0] !== 12'h040 || wl_addr[1] !== 12'h041) begin
      errors++;
      $display("FAIL midreset_restart writes=%0d wen0=%h addr0=%h addr1=%h want 2 1 040 041",
               wn, wl_wen[0], wl_addr[0], wl_addr[1]);
    end
  endtask

  task automatic test_addr_wrap();
    logic [63:0] d  [4];
    logic [11:0] ea [4];
    logic [7:0]  ep [4];
    d[0] = 64'h0000_0000_0000_0003; ea[0] = 12'hFFE; ep[0] = 8'h00;
    d[1] = 64'h0000_0000_0000_0001; ea[1] = 12'hFFF; ep[1] = 8'h01;
    d[2] = 64'hFF00_0000_0000_0080; ea[2] = 12'h000; ep[2] = 8'h01;
    d[3] = 64'h0100_0000_0000_0000; ea[3] = 12'h001; ep[3] = 8'h80;
    clear_log();
    cfg_base_addr = 12'hFFE; cfg_bank_depth = 12'd4; cfg_word_num = 16'd4;
    for (int i = 0; i < 4; i++) begin
      send(d[i], i == 3);
      checks++;
      if (sram_wen !== 4'b0001 || sram_addr !== ea[i] || sram_wdata !== d[i]) begin
        errors++;
        $display("FAIL awrap%0d wen=%h addr=%h wd=%h want 1 %h %h", i, sram_wen, sram_addr, sram_wdata, ea[i], d[i]);
      end
`ifdef DS_PARITY_EN
      checks++;
      if (sram_wpar !== ep[i]) begin
        errors++; $display("FAIL parity%0d wpar=%h want %h", i, sram_wpar, ep[i]);
      end
`endif
    end
    finish_load();
    checks++;
    if (ld_err !== 1'b0 || done_cnt !== 1 || sram_wen !== 4'b0) begin
      errors++; $display("FAIL awrap_end err=%0b done=%0d wen=%h want 0 1 0", ld_err, done_cnt, sram_wen);
    end
`ifdef DS_PARITY_EN
    checks++;
    if (sram_wpar !== 8'h00) begin errors++; $display("FAIL parity_idle wpar=%h want 00", sram_wpar); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_bank_wrap();
    test_len_err();
    test_reset_mid();
    test_addr_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
